// File: rtl/pin_mux_pkg.sv
// Shared constants for the pin multiplexer: register map, select field layout
// and select encoding.
package pin_mux_pkg;

  localparam logic [3:0] ADDR_OUT   = 4'd0;
  localparam logic [3:0] ADDR_DIR   = 4'd1;
  localparam logic [3:0] ADDR_IN    = 4'd2;
  localparam logic [3:0] ADDR_EDGE  = 4'd3;
  localparam logic [3:0] ADDR_IRQEN = 4'd4;
  localparam logic [3:0] ADDR_SET   = 4'd5;
  localparam logic [3:0] ADDR_CLR   = 4'd6;

  localparam int unsigned MSEL_W        = 4;
  localparam int unsigned PINS_PER_WORD = 8;

  typedef logic [MSEL_W-1:0] msel_t;

  localparam msel_t SEL_GPIO = '0;

  // Select words occupy addresses 8..11; the low two address bits pick the word.
  function automatic logic is_msel_addr(input logic [3:0] addr);
    return addr[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/pin_mux_in_filter.sv
// Per-pin input conditioning: 2-flop synchroniser, stability filter and a
// registered one-cycle pulse whenever the filtered value changes.
module pin_mux_in_filter #(
  parameter int unsigned FILT = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic filt_o,
  output logic chg_o
);

  localparam int unsigned CntW = (FILT < 2) ? 1 : $clog2(FILT);

  logic            sync1_q, sync2_q;
  logic            filt_q, filt_d;
  logic            chg_q, chg_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive cycles the synchronised value differs from filt_q.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    chg_d  = 1'b0;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(FILT - 1)) begin
      filt_d = sync2_q;
      cnt_d  = '0;
      chg_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign chg_o  = chg_q;

endmodule

// File: rtl/pin_mux_ctrl.sv
// Per-pin I/O multiplexer with Avalon-MM registers: GPIO or alternate-source drive
// with break-before-make select changes, and filtered, edge-flagged inputs.
module pin_mux_ctrl
  import pin_mux_pkg::*;
#(
  parameter int unsigned PINS = 32,
  parameter int unsigned SRCS = 3,
  parameter int unsigned GAP  = 4,
  parameter int unsigned FILT = 3
) (
  input  logic                 iCLK,
  input  logic                 iRESETn,
  input  logic [3:0]           iAVL_ADDRESS,
  input  logic                 iAVL_WRITE,
  input  logic [31:0]          iAVL_WRITEDATA,
  input  logic                 iAVL_READ,
  output logic [31:0]          oAVL_READDATA,
  input  logic [SRCS*PINS-1:0] iALT_O,
  input  logic [SRCS*PINS-1:0] iALT_OE,
  input  logic [PINS-1:0]      iPIN_I,
  output logic [PINS-1:0]      oPIN_O,
  output logic [PINS-1:0]      oPIN_OE,
  output logic [PINS-1:0]      oPIN_IN,
  output logic                 oIRQ
);

  logic [PINS-1:0] out_q, out_d;
  logic [PINS-1:0] dir_q, dir_d;
  logic [PINS-1:0] edge_q, edge_d;
  logic [PINS-1:0] irqen_q, irqen_d;

  // msel_q is the software-visible target; esel_q is what actually drives the pad.
  msel_t [PINS-1:0] msel_q, msel_d;
  msel_t [PINS-1:0] esel_q, esel_d;
  logic  [PINS-1:0][3:0] gcnt_q, gcnt_d;

  logic [PINS-1:0] pin_o_q, pin_o_d;
  logic [PINS-1:0] pin_oe_q, pin_oe_d;
  logic [PINS-1:0] in_filt, in_chg;
  logic [31:0]     rdata_q, rdata_d;
  logic            irq_q, irq_d;
  logic [PINS-1:0] wdata;

  assign wdata = iAVL_WRITEDATA[PINS-1:0];

  for (genvar p = 0; p < PINS; p++) begin : g_in
    pin_mux_in_filter #(
      .FILT(FILT)
    ) u_filt (
      .clk_i (iCLK),
      .rst_ni(iRESETn),
      .pin_i (iPIN_I[p]),
      .filt_o(in_filt[p]),
      .chg_o (in_chg[p])
    );
  end

  // Register writes, gap countdown and sticky edge flags.
  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    irqen_d = irqen_q;
    edge_d  = edge_q | in_chg;
    msel_d  = msel_q;
    esel_d  = esel_q;
    gcnt_d  = gcnt_q;

    for (int unsigned p = 0; p < PINS; p++) begin
      if (gcnt_q[p] != 4'd0) begin
        gcnt_d[p] = gcnt_q[p] - 4'd1;
        if (gcnt_q[p] == 4'd1) begin
          esel_d[p] = msel_q[p];
        end
      end
    end

    if (iAVL_WRITE) begin
      case (iAVL_ADDRESS)
        ADDR_OUT:   out_d   = wdata;
        ADDR_DIR:   dir_d   = wdata;
        ADDR_EDGE:  edge_d  = (edge_q & ~wdata) | in_chg;
        ADDR_IRQEN: irqen_d = wdata;
        ADDR_SET:   out_d   = out_q | wdata;
        ADDR_CLR:   out_d   = out_q & ~wdata;
        default: begin
          if (is_msel_addr(iAVL_ADDRESS)) begin
            for (int unsigned p = 0; p < PINS; p++) begin
              if (iAVL_ADDRESS[1:0] == 2'(p / PINS_PER_WORD) &&
                  iAVL_WRITEDATA[(p % PINS_PER_WORD) * MSEL_W +: MSEL_W] != msel_q[p]) begin
                msel_d[p] = iAVL_WRITEDATA[(p % PINS_PER_WORD) * MSEL_W +: MSEL_W];
                gcnt_d[p] = 4'(GAP);
              end
            end
          end
        end
      endcase
    end

    irq_d = |(edge_d & irqen_d);
  end

  // Pad drive from the effective select; selects above SRCS leave the pin idle.
  always_comb begin
    pin_o_d  = '0;
    pin_oe_d = '0;
    for (int unsigned p = 0; p < PINS; p++) begin
      if (gcnt_q[p] == 4'd0) begin
        if (esel_q[p] == SEL_GPIO) begin
          pin_oe_d[p] = dir_q[p];
          pin_o_d[p]  = out_q[p] & dir_q[p];
        end
        for (int unsigned k = 0; k < SRCS; k++) begin
          if (esel_q[p] == MSEL_W'(k + 1)) begin
            pin_o_d[p]  = iALT_O[k * PINS + p];
            pin_oe_d[p] = iALT_OE[k * PINS + p];
          end
        end
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    case (iAVL_ADDRESS)
      ADDR_OUT:   rdata_d[PINS-1:0] = out_q;
      ADDR_DIR:   rdata_d[PINS-1:0] = dir_q;
      ADDR_IN:    rdata_d[PINS-1:0] = in_filt;
      ADDR_EDGE:  rdata_d[PINS-1:0] = edge_q;
      ADDR_IRQEN: rdata_d[PINS-1:0] = irqen_q;
      default: begin
        if (is_msel_addr(iAVL_ADDRESS)) begin
          for (int unsigned p = 0; p < PINS; p++) begin
            if (iAVL_ADDRESS[1:0] == 2'(p / PINS_PER_WORD)) begin
              rdata_d[(p % PINS_PER_WORD) * MSEL_W +: MSEL_W] = msel_q[p];
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      out_q    <= '0;
      dir_q    <= '0;
      edge_q   <= '0;
      irqen_q  <= '0;
      msel_q   <= '0;
      esel_q   <= '0;
      gcnt_q   <= '0;
      pin_o_q  <= '0;
      pin_oe_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      edge_q   <= edge_d;
      irqen_q  <= irqen_d;
      msel_q   <= msel_d;
      esel_q   <= esel_d;
      gcnt_q   <= gcnt_d;
      pin_o_q  <= pin_o_d;
      pin_oe_q <= pin_oe_d;
      irq_q    <= irq_d;
      if (iAVL_READ) begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign oPIN_O        = pin_o_q;
  assign oPIN_OE       = pin_oe_q;
  assign oPIN_IN       = in_filt;
  assign oIRQ          = irq_q;
  assign oAVL_READDATA = rdata_q;

endmodule

// File: tb/tb_pin_mux_ctrl.sv
// Directed bench for pin_mux_ctrl with default parameters (32 pins, 3 sources,
// GAP=4, FILT=3); expected values are hand-computed per step.
module tb_pin_mux_ctrl;

  localparam int unsigned PINS = 32;
  localparam int unsigned SRCS = 3;

  logic                 iCLK;
  logic                 iRESETn;
  logic [3:0]           iAVL_ADDRESS;
  logic                 iAVL_WRITE;
  logic [31:0]          iAVL_WRITEDATA;
  logic                 iAVL_READ;
  logic [31:0]          oAVL_READDATA;
  logic [SRCS*PINS-1:0] iALT_O;
  logic [SRCS*PINS-1:0] iALT_OE;
  logic [PINS-1:0]      iPIN_I;
  logic [PINS-1:0]      oPIN_O;
  logic [PINS-1:0]      oPIN_OE;
  logic [PINS-1:0]      oPIN_IN;
  logic                 oIRQ;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdv;

  pin_mux_ctrl #(
    .PINS(PINS),
    .SRCS(SRCS),
    .GAP (4),
    .FILT(3)
  ) dut (
    .iCLK          (iCLK),
    .iRESETn       (iRESETn),
    .iAVL_ADDRESS  (iAVL_ADDRESS),
    .iAVL_WRITE    (iAVL_WRITE),
    .iAVL_WRITEDATA(iAVL_WRITEDATA),
    .iAVL_READ     (iAVL_READ),
    .oAVL_READDATA (oAVL_READDATA),
    .iALT_O        (iALT_O),
    .iALT_OE       (iALT_OE),
    .iPIN_I        (iPIN_I),
    .oPIN_O        (oPIN_O),
    .oPIN_OE       (oPIN_OE),
    .oPIN_IN       (oPIN_IN),
    .oIRQ          (oIRQ)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    iAVL_ADDRESS   = a;
    iAVL_WRITEDATA = d;
    iAVL_WRITE     = 1'b1;
    tick();
    iAVL_WRITE     = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    iAVL_ADDRESS = a;
    iAVL_READ    = 1'b1;
    tick();
    iAVL_READ    = 1'b0;
    d            = oAVL_READDATA;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    iRESETn        = 1'b1;
    iAVL_ADDRESS   = '0;
    iAVL_WRITE     = 1'b0;
    iAVL_WRITEDATA = '0;
    iAVL_READ      = 1'b0;
    iALT_O         = '0;
    iALT_OE        = '0;
    iPIN_I         = '0;
    #2 iRESETn = 1'b0;
    tick();
    tick();
    chk("rst_oe", 32'(oPIN_OE), 32'h0);
    chk("rst_irq", 32'(oIRQ), 32'h0);
    @(negedge iCLK);
    iRESETn = 1'b1;
    tick();

    // Every address reads 0 after reset.
    for (int a = 0; a < 12; a++) begin
      rd(4'(a), rdv);
      chk($sformatf("rst_rd%0d", a), rdv, 32'h0);
    end
    chk("rst_pin_o", 32'(oPIN_O), 32'h0);

    // GPIO output on pin 0, then SET/CLR.
    wr(4'd1, 32'h1);
    wr(4'd0, 32'h1);
    chk("gpio_o_before", 32'(oPIN_O[0]), 32'h0);
    tick();
    chk("gpio_o", 32'(oPIN_O[0]), 32'h1);
    chk("gpio_oe", 32'(oPIN_OE[0]), 32'h1);
    wr(4'd5, 32'h2);
    wr(4'd6, 32'h1);
    rd(4'd0, rdv);
    chk("set_clr_out", rdv, 32'h2);
    rd(4'd6, rdv);
    chk("clr_reads0", rdv, 32'h0);

    // Pin 3: GPIO output driving 0, then switch to source 2 (OE=1, O=1).
    wr(4'd1, 32'h9);
    iALT_OE[35] = 1'b1;
    iALT_O[35]  = 1'b1;
    tick();
    chk("p3_gpio_oe", 32'(oPIN_OE[3]), 32'h1);
    chk("p3_gpio_o", 32'(oPIN_O[3]), 32'h0);
    wr(4'd8, 32'h2000);
    chk("p3_pre_gap", 32'(oPIN_OE[3]), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("p3_gap%0d_oe", i), 32'(oPIN_OE[3]), 32'h0);
    end
    tick();
    chk("p3_src2_oe", 32'(oPIN_OE[3]), 32'h1);
    chk("p3_src2_o", 32'(oPIN_O[3]), 32'h1);
    rd(4'd8, rdv);
    chk("msel8_rd", rdv, 32'h2000);
    wr(4'd8, 32'h2000);
    tick();
    chk("rewrite_nogap0", 32'(oPIN_OE[3]), 32'h1);
    tick();
    chk("rewrite_nogap1", 32'(oPIN_OE[3]), 32'h1);

    // Gap restart: source 1 (OE=1, O=0) then source 3 (OE=1, O=1) mid-gap.
    iALT_OE[3]  = 1'b1;
    iALT_O[3]   = 1'b0;
    iALT_OE[67] = 1'b1;
    iALT_O[67]  = 1'b1;
    wr(4'd8, 32'h1000);
    tick();
    chk("rs_idle1", 32'(oPIN_OE[3]), 32'h0);
    tick();
    chk("rs_idle2", 32'(oPIN_OE[3]), 32'h0);
    wr(4'd8, 32'h3000);
    chk("rs_idle3", 32'(oPIN_OE[3]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rs_fresh%0d", i), 32'(oPIN_OE[3]), 32'h0);
    end
    tick();
    chk("rs_src3_oe", 32'(oPIN_OE[3]), 32'h1);
    chk("rs_src3_o", 32'(oPIN_O[3]), 32'h1);

    // Select beyond SRCS leaves the pin idle.
    wr(4'd8, 32'hF000);
    repeat (8) tick();
    chk("selF_oe", 32'(oPIN_OE[3]), 32'h0);
    chk("selF_o", 32'(oPIN_O[3]), 32'h0);

    // 2-cycle glitch on pin 5 is filtered out.
    iPIN_I[5] = 1'b1;
    tick();
    tick();
    iPIN_I[5] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("glitch_in%0d", i), 32'(oPIN_IN[5]), 32'h0);
    end
    rd(4'd3, rdv);
    chk("glitch_edge", rdv, 32'h0);

    // Steady high: IN after 5 cycles, EDGE/IRQ one cycle later.
    wr(4'd4, 32'h20);
    iPIN_I[5] = 1'b1;
    repeat (4) tick();
    chk("in5_c4", 32'(oPIN_IN[5]), 32'h0);
    tick();
    chk("in5_c5", 32'(oPIN_IN[5]), 32'h1);
    chk("irq_c5", 32'(oIRQ), 32'h0);
    tick();
    chk("irq_c6", 32'(oIRQ), 32'h1);
    rd(4'd3, rdv);
    chk("edge_set", rdv, 32'h20);
    rd(4'd2, rdv);
    chk("in_reg", rdv, 32'h20);
    repeat (3) tick();
    wr(4'd3, 32'h20);
    chk("w1c_irq", 32'(oIRQ), 32'h0);
    rd(4'd3, rdv);
    chk("w1c_edge", rdv, 32'h0);

    // Falling edge flagged in the same cycle as a W1C: set wins.
    iPIN_I[5] = 1'b0;
    repeat (5) tick();
    chk("fall_in", 32'(oPIN_IN[5]), 32'h0);
    wr(4'd3, 32'h20);
    chk("coinc_irq", 32'(oIRQ), 32'h1);
    rd(4'd3, rdv);
    chk("coinc_edge", rdv, 32'h20);

    // Asynchronous reset mid-gap and mid-filter.
    wr(4'd8, 32'h0000);
    iPIN_I[5] = 1'b1;
    tick();
    tick();
    chk("pre_rst_oe0", 32'(oPIN_OE[0]), 32'h1);
    #3 iRESETn = 1'b0;
    #1;
    chk("arst_oe", 32'(oPIN_OE), 32'h0);
    chk("arst_o", 32'(oPIN_O), 32'h0);
    chk("arst_irq", 32'(oIRQ), 32'h0);
    chk("arst_rdata", oAVL_READDATA, 32'h0);
    iPIN_I[5] = 1'b0;
    repeat (3) tick();
    @(negedge iCLK);
    iRESETn = 1'b1;
    repeat (10) tick();
    chk("post_oe", 32'(oPIN_OE), 32'h0);
    chk("post_in", 32'(oPIN_IN), 32'h0);
    chk("post_irq", 32'(oIRQ), 32'h0);
    rd(4'd3, rdv);
    chk("post_edge", rdv, 32'h0);
    rd(4'd8, rdv);
    chk("post_msel", rdv, 32'h0);
    rd(4'd1, rdv);
    chk("post_dir", rdv, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pin_mux_ctrl.md
# pin_mux_ctrl

Parametrised per-pin I/O multiplexer with an Avalon-MM register slave, for MKR/NINA/PCIe header banks. Each pin is driven either by a software GPIO (OUT/DIR registers) or by one of SRCS alternate peripheral sources, and each pin has a 4-bit select. Mode changes go through a break-before-make gap, so two drivers never overlap on a pin. Inputs are synchronised, glitch-filtered and edge-flagged with an interrupt; the top level keeps only the tristate buffers.

## Interface
- PINS, 32, number of pins (1..32)
- SRCS, 3, number of alternate sources (1..14); select 0 = GPIO, 1..SRCS = alternate source
- GAP, 4, break-before-make idle cycles on select change (1..15)
- FILT, 3, input stability cycles before the filtered value updates (1..15)

- iCLK  in  1  system clock; all logic is in this single domain
- iRESETn  in  1  asynchronous, active-low reset
- iAVL_ADDRESS  in  4  word address
- iAVL_WRITE  in  1  write strobe
- iAVL_WRITEDATA  in  32  write data
- iAVL_READ  in  1  read strobe
- oAVL_READDATA  out  32  read data, fixed latency 1, no waitrequest
- iALT_O  in  SRCS*PINS  alternate output data; source k occupies bits [(k-1)*PINS +: PINS]
- iALT_OE  in  SRCS*PINS  alternate output enables, same packing as iALT_O
- iPIN_I  in  PINS  raw pad inputs, asynchronous
- oPIN_O  out  PINS  pad output data, registered
- oPIN_OE  out  PINS  pad output enable, registered
- oPIN_IN  out  PINS  filtered pad inputs, exported for peripherals
- oIRQ  out  1  registered level interrupt, equal to |(EDGE & IRQEN)

## Operation
- Register map, one 32-bit word per address:
  - 0: OUT, read/write
  - 1: DIR, read/write
  - 2: IN, read-only filtered inputs
  - 3: EDGE, sticky change flags, write-1-to-clear
  - 4: IRQEN, read/write
  - 5: SET, write-only, OUT |= data
  - 6: CLR, write-only, OUT &= ~data
  - 8..11: MSEL, 8 pins per word, 4 bits per pin; pin p is in word 8+p/8, bits [(p%8)*4 +: 4]
  - Other addresses read 0; writes to them are ignored.
- Bits for pins ≥ PINS read 0 and ignore writes.
- Simultaneous SET and CLR cannot occur: there is a single write port.
- Each pin has an effective select ESEL and a gap counter GCNT.
- A write that changes a pin's MSEL field loads GCNT=GAP and stores the target value.
- While GCNT≠0 the pin is idle (oPIN_OE=0, oPIN_O=0) and GCNT decrements each cycle; when it reaches 0, ESEL takes the target.
- Writing a field with its current value: no effect, no gap.
- Writing a new value during a gap reloads GCNT=GAP with the new target.
- Drive per pin, from ESEL:
  - ESEL=0: oPIN_OE=DIR, oPIN_O=OUT&DIR.
  - ESEL=1..SRCS: oPIN_O and oPIN_OE from the matching source's iALT_O/iALT_OE bit.
  - ESEL>SRCS: permanently idle.
- Input path per pin:
  - 2-flop synchroniser, then the filter.
  - The filtered bit takes the synchronised value after it has been stable for FILT consecutive cycles.
  - Any change of the filtered bit sets its EDGE flag.
  - A set and a W1C in the same cycle: set wins.
- Reset values:
  - All registers 0, so every pin is GPIO input.
  - GCNT=0, ESEL=0, synchronisers and filters 0.
  - Outputs: oPIN_O=0, oPIN_OE=0, oPIN_IN=0, oIRQ=0, oAVL_READDATA=0.
- Reset asserted mid-gap or mid-filter aborts the operation immediately; outputs return to their reset values asynchronously.

## Timing
- E0 is the edge that samples an access.
- Write at E0: the register holds the new value after E0; oPIN_O/oPIN_OE reflect it after E1.
- Read at E0: oAVL_READDATA valid after E0 and held until the next read.
- Select change written at E0: pin idle after E1..E_GAP, new source drives after E_{GAP+1}. GAP=4 gives 4 idle cycles.
- Alternate source to pad: 1 cycle, registered.
- Input latency: pad change to oPIN_IN/IN is 2+FILT cycles; EDGE and oIRQ follow 1 cycle later.
- A glitch shorter than FILT synchronised cycles never reaches oPIN_IN.

## Structure
- Package pin_mux_pkg holds:
  - register address constants
  - MSEL field width (4) and pins-per-word (8)
  - select encoding constant SEL_GPIO=0
- Sub-module pin_mux_in_filter: one instance per pin (generate loop), containing synchroniser, stability counter and change pulse, parametrised by FILT.
- The gap/ESEL logic stays inline.

## Test plan
- Reset, then read addresses 0..11 → all 0; oPIN_OE=0, oIRQ=0.
- DIR=0x1, OUT=0x1 → pin0 oPIN_OE=1, oPIN_O=1 one cycle after the OUT write. SET 0x2 then CLR 0x1 → OUT reads 0x2.
- Pin3 running GPIO output, MSEL word 8 written 0x2000 with source 2 pin3 OE=1, O=1 → pin3 OE=0 for exactly 4 cycles, then OE=1, O=1. Rewriting 0x2000 → no gap.
- Select changed again at gap cycle 2 → gap restarts (4 fresh idle cycles). Select 0xF written with SRCS=3 → pin stays idle.
- iPIN_I[5] pulse of 2 cycles with FILT=3 → no change. Held high 10 cycles → IN[5]=1 at cycle 5, EDGE[5]=1, oIRQ=1 with IRQEN=0x20. W1C 0x20 → oIRQ=0 next cycle. W1C coinciding with a new edge → flag stays 1.
- iRESETn asserted during a gap and during filter counting → outputs 0 immediately. After release: GPIO input mode, no spurious EDGE.
